// File: rtl/midi_rx_parser.sv
// MIDI serial receiver (8N1) with a monophonic, last-note-priority note parser.
// Handles running status and interleaved real-time bytes on one selected channel.
module midi_rx_parser #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int BAUD    = 31250,
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       midi_rx,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic [7:0] amplitude,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] CH = 4'(CHANNEL);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {WAIT_STATUS, WAIT_NOTE, WAIT_VEL} parse_state_t;

  uart_state_t  u_state, u_next;
  parse_state_t p_state, p_next;

  logic          rx_meta, rx_sync;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          break_wait;
  logic          tick;
  logic [6:0]    note;
  logic          note_on;
  logic          is_rt, is_voice;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= midi_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) u_state <= U_IDLE;
    else        u_state <= u_next;
  end

  // After a bad stop bit the line may sit low (break); stay in STOP until it returns high.
  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE:  if (!rx_sync) u_next = U_START;
      U_START: if (tick) u_next = rx_sync ? U_IDLE : U_DATA;
      U_DATA:  if (tick && bit_idx == 3'd7) u_next = U_STOP;
      U_STOP: begin
        if (break_wait) begin
          if (rx_sync) u_next = U_IDLE;
        end else if (tick && rx_sync) begin
          u_next = U_IDLE;
        end
      end
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      break_wait <= 1'b0;
      rx_byte    <= '0;
      rx_strobe  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (u_state)
        U_IDLE: begin
          baud_cnt   <= HALF_LOAD;
          bit_idx    <= '0;
          break_wait <= 1'b0;
        end
        U_START: begin
          if (tick) baud_cnt <= FULL_LOAD;
          else      baud_cnt <= baud_cnt - CW'(1);
        end
        U_DATA: begin
          if (tick) begin
            shreg    <= {rx_sync, shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            baud_cnt <= FULL_LOAD;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        U_STOP: begin
          if (!break_wait) begin
            if (tick) begin
              if (rx_sync) begin
                rx_byte   <= shreg;
                rx_strobe <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
                break_wait <= 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign is_rt    = (rx_byte[7:3] == 5'b11111);
  assign is_voice = (rx_byte[7:5] == 3'b100) && (rx_byte[3:0] == CH);

  always_ff @(posedge clk) begin
    if (!rst_n) p_state <= WAIT_STATUS;
    else        p_state <= p_next;
  end

  // WAIT_STATUS doubles as "no running status"; any non-real-time status byte restarts the message.
  always_comb begin
    p_next = p_state;
    if (rx_strobe) begin
      if (rx_byte[7]) begin
        if (!is_rt) p_next = is_voice ? WAIT_NOTE : WAIT_STATUS;
      end else begin
        case (p_state)
          WAIT_NOTE: p_next = WAIT_VEL;
          WAIT_VEL:  p_next = WAIT_NOTE;
          default:   p_next = p_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      note       <= '0;
      note_on    <= 1'b0;
      midi_data  <= '0;
      midi_valid <= 1'b0;
      amplitude  <= '0;
    end else if (rx_strobe) begin
      if (rx_byte[7]) begin
        if (is_voice) note_on <= rx_byte[4];
      end else if (p_state == WAIT_NOTE) begin
        note <= rx_byte[6:0];
      end else if (p_state == WAIT_VEL) begin
        if (note_on && rx_byte[6:0] != 7'd0) begin
          midi_data  <= {1'b0, note};
          amplitude  <= {rx_byte[6:0], 1'b0};
          midi_valid <= 1'b1;
        end else if (midi_valid && {1'b0, note} == midi_data) begin
          midi_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Self-checking bench for midi_rx_parser: directed scenarios plus random byte streams
// compared against a message-level model of the note parser.
module tb_midi_rx_parser;

  localparam int BAUD  = 31250;
  localparam int FAST_HZ = 500_000;
  localparam int CPB = FAST_HZ / BAUD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, midi_rx, full_rx;
  logic [7:0] midi_data, amplitude, rx_byte;
  logic       midi_valid, rx_strobe, frame_err;
  logic [7:0] full_data, full_amp, full_byte;
  logic       full_valid, full_strobe, full_ferr;

  midi_rx_parser #(.CLK_HZ(FAST_HZ), .BAUD(BAUD), .CHANNEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .midi_rx(midi_rx),
    .midi_data(midi_data), .midi_valid(midi_valid), .amplitude(amplitude),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .frame_err(frame_err)
  );

  midi_rx_parser dut_full (
    .clk(clk), .rst_n(rst_n), .midi_rx(full_rx),
    .midi_data(full_data), .midi_valid(full_valid), .amplitude(full_amp),
    .rx_byte(full_byte), .rx_strobe(full_strobe), .frame_err(full_ferr)
  );

  int checks = 0;
  int failures = 0;

  int strobe_cnt = 0, ferr_cnt = 0, full_events = 0;
  int cyc = 0, last_strobe_cyc = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rx_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
    if (full_strobe || full_ferr) full_events++;
    if (midi_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = midi_valid;
  end

  int m_data, m_valid, m_amp, m_rx_byte, m_voice;
  int pend[$];

  function automatic void modelReset();
    m_data = 0; m_valid = 0; m_amp = 0; m_rx_byte = 0; m_voice = -1;
    pend.delete();
  endfunction

  // m_voice: -1 no running status, 0 note-off, 1 note-on; pend holds data bytes of the open message.
  function automatic void modelByte(input logic [7:0] b);
    m_rx_byte = int'(b);
    if (b[7]) begin
      if (b < 8'hF8) begin
        pend.delete();
        if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && b[3:0] == 4'h0) m_voice = (b[7:4] == 4'h9) ? 1 : 0;
        else m_voice = -1;
      end
    end else if (m_voice >= 0) begin
      pend.push_back(int'(b));
      if (pend.size() == 2) begin
        if (m_voice == 1 && pend[1] != 0) begin
          m_data = pend[0]; m_amp = pend[1] * 2; m_valid = 1;
        end else if (m_valid == 1 && pend[0] == m_data) begin
          m_valid = 0;
        end
        pend.delete();
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_data"}, int'(midi_data), m_data);
    checkOutput({tag, "_valid"}, int'(midi_valid), m_valid);
    checkOutput({tag, "_amp"}, int'(amplitude), m_amp);
    checkOutput({tag, "_rxbyte"}, int'(rx_byte), m_rx_byte);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit good_stop, input string tag);
    int s0, f0;
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    midi_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_rx = good_stop;
    repeat (CPB) @(negedge clk);
    midi_rx = 1'b1;
    repeat (good_stop ? 4 : 2 * CPB) @(negedge clk);
    if (good_stop) modelByte(b);
    checkOutput({tag, "_strobes"}, strobe_cnt - s0, good_stop ? 1 : 0);
    checkOutput({tag, "_ferr"}, ferr_cnt - f0, good_stop ? 0 : 1);
    checkModel(tag);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, f0, e0, r;
    logic [7:0] b;
    rst_n = 1'b0;
    midi_rx = 1'b1;
    full_rx = 1'b1;
    modelReset();
    repeat (4) @(negedge clk);
    checkOutput("rst_data", int'(midi_data), 0);
    checkOutput("rst_valid", int'(midi_valid), 0);
    checkOutput("rst_amp", int'(amplitude), 0);
    checkOutput("rst_rxbyte", int'(rx_byte), 0);
    checkOutput("rst_strobe", int'(rx_strobe), 0);
    checkOutput("rst_ferr", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus(8'h90, 1'b1, "t1_status");
    applyStimulus(8'h3C, 1'b1, "t1_note");
    applyStimulus(8'h64, 1'b1, "t1_vel");
    checkOutput("t1_data_const", int'(midi_data), 'h3C);
    checkOutput("t1_amp_const", int'(amplitude), 'hC8);
    checkOutput("t1_latency", rise_cyc - last_strobe_cyc, 1);

    applyStimulus(8'h40, 1'b1, "t2_note");
    applyStimulus(8'h50, 1'b1, "t2_vel");
    checkOutput("t2_data_const", int'(midi_data), 'h40);
    checkOutput("t2_amp_const", int'(amplitude), 'hA0);
    applyStimulus(8'h3C, 1'b1, "t2_stale_note");
    applyStimulus(8'h00, 1'b1, "t2_stale_off");
    checkOutput("t2_stale_valid", int'(midi_valid), 1);
    applyStimulus(8'h40, 1'b1, "t2_off_note");
    applyStimulus(8'h00, 1'b1, "t2_off_vel");
    checkOutput("t2_off_valid", int'(midi_valid), 0);
    checkOutput("t2_off_data", int'(midi_data), 'h40);

    s0 = strobe_cnt;
    applyStimulus(8'h91, 1'b1, "t3_status");
    applyStimulus(8'h3C, 1'b1, "t3_note");
    applyStimulus(8'h64, 1'b1, "t3_vel");
    checkOutput("t3_strobes", strobe_cnt - s0, 3);
    checkOutput("t3_valid", int'(midi_valid), 0);

    applyStimulus(8'h90, 1'b1, "t4_status");
    applyStimulus(8'hF8, 1'b1, "t4_clock");
    applyStimulus(8'h3C, 1'b1, "t4_note");
    applyStimulus(8'hFE, 1'b1, "t4_sense");
    applyStimulus(8'h64, 1'b1, "t4_vel");
    checkOutput("t4_data_const", int'(midi_data), 'h3C);
    checkOutput("t4_amp_const", int'(amplitude), 'hC8);
    checkOutput("t4_valid_const", int'(midi_valid), 1);

    applyStimulus(8'h55, 1'b0, "t5_badstop");

    // A low pulse shorter than half a bit must be rejected as a glitch on both instances.
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    e0 = full_events;
    midi_rx = 1'b0;
    full_rx = 1'b0;
    repeat (5) @(negedge clk);
    midi_rx = 1'b1;
    repeat (95) @(negedge clk);
    full_rx = 1'b1;
    repeat (4 * CPB + 400) @(negedge clk);
    checkOutput("t5_glitch_strobes", strobe_cnt - s0, 0);
    checkOutput("t5_glitch_ferr", ferr_cnt - f0, 0);
    checkOutput("t5_full_glitch_events", full_events - e0, 0);
    checkOutput("t5_full_valid", int'(full_valid), 0);
    checkModel("t5_after_glitch");

    applyStimulus(8'h90, 1'b1, "t6_status");
    applyStimulus(8'h3C, 1'b1, "t6_note");
    pulseReset();
    applyStimulus(8'h64, 1'b1, "t6_vel");
    checkOutput("t6_data_zero", int'(midi_data), 0);
    checkOutput("t6_valid_zero", int'(midi_valid), 0);
    checkOutput("t6_amp_zero", int'(amplitude), 0);

    applyStimulus(8'h90, 1'b1, "t7_status");
    applyStimulus(8'h30, 1'b1, "t7_note");
    applyStimulus(8'h7F, 1'b1, "t7_vel");
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    midi_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    midi_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (3 * CPB) @(negedge clk);
    checkOutput("t7_abort_strobes", strobe_cnt - s0, 0);
    checkOutput("t7_abort_ferr", ferr_cnt - f0, 0);
    checkModel("t7_abort");

    pulseReset();
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 2)       b = 8'h90;
      else if (r == 3)  b = 8'h80;
      else if (r == 4)  b = 8'h80 | 8'($urandom_range(0, 31));
      else if (r == 5)  b = 8'hF8 | 8'($urandom_range(0, 7));
      else if (r == 6)  b = 8'hF0 | 8'($urandom_range(0, 7));
      else if (r == 7)  b = 8'hA0 | 8'($urandom_range(0, 79));
      else if (r <= 13) b = 8'h3C + 8'(4 * $urandom_range(0, 3));
      else if (r <= 16) b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
      else              b = 8'($urandom_range(0, 127));
      applyStimulus(b, ($urandom_range(0, 19) != 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
